vz_image_loader: RTL and testbench
==================================

// Module: vz_image_loader
// PURPOSE
//  Parametrised VZ-image loader between the hps_io ioctl download port and Laser310 main RAM.
//  Supersedes the fixed ioctl wiring: validates the VZ header, extracts type and start address,
//  streams payload bytes to RAM through a FIFO with a req/ack handshake, and back-pressures HPS.
//  Reports the loaded range and type so the CPU glue can patch BASIC pointers or jump to code.
// PARAMETERS
//  ADDR_W      16           RAM address width; also the width of dn_addr.
//  HDR_LEN     24           VZ header length in bytes; payload begins at offset HDR_LEN.
//  IDX_VZ      8'd1         ioctl index this loader responds to; all other indices are ignored.
//  MAGIC       32'h565A4630 required bytes 0..3 ("VZF0"), byte 0 in MAGIC[31:24].
//  TYPE_OFS    21           header offset of the type byte (F0=BASIC, F1=binary).
//  START_OFS   22           header offset of start address: LSB at START_OFS, MSB at START_OFS+1.
//  FIFO_DEPTH  4            payload FIFO entries; power of two, >=2.
// PORTS
//  clk_sys      in   1       system clock; every register is clocked on its rising edge.
//  reset        in   1       synchronous, active-high.
//  dn_download  in   1       ioctl_download.
//  dn_index     in   8       ioctl_index.
//  dn_wr        in   1       ioctl_wr: one-cycle byte strobe.
//  dn_addr      in   ADDR_W  ioctl_addr: byte offset within the file.
//  dn_data      in   8       ioctl_dout.
//  dn_wait      out  1       to ioctl_wait: holds HPS off while the FIFO is full or draining.
//  mem_req      out  1       RAM write request.
//  mem_addr     out  ADDR_W  RAM write address.
//  mem_dout     out  8       RAM write data.
//  mem_ack      in   1       RAM accepted the request in this cycle.
//  busy         out  1       a load is in progress, including FIFO drain (LED / CPU hold).
//  load_done    out  1       one-cycle pulse: successful load completed.
//  load_err     out  1       level: the last load failed; cleared when the next load starts.
//  load_type    out  8       type byte from the last header.
//  start_addr   out  ADDR_W  start address from the last header.
//  end_addr     out  ADDR_W  last written address + 1 (wraps to 0 at 2^ADDR_W).
// BEHAVIOUR
//  Reset: every output is 0, FIFO is emptied, FSM goes to IDLE. This applies in any state,
//   including mid-load; no further mem_req is issued for the aborted load.
//  A load is active only when dn_index==IDX_VZ. A dn_wr with any other index is ignored.
//  States: IDLE, HEADER, PAYLOAD, DRAIN, ERROR.
//   IDLE->HEADER on a dn_download rising edge: clears load_err, busy=1, expected offset=0.
//   HEADER: byte k (k<HDR_LEN) is captured. Bytes 0..3 are compared with MAGIC.
//    A mismatch goes to ERROR.
//    TYPE_OFS and START_OFS/+1 are latched into load_type and start_addr.
//    The byte at HDR_LEN-1 moves the FSM to PAYLOAD and sets end_addr=start_addr.
//   PAYLOAD: payload byte p is pushed as {start_addr+p, data} and end_addr is incremented on
//    each push.
//    If start_addr+p would exceed 2^ADDR_W-1, the byte is not pushed and the FSM goes to ERROR.
//   Order check: any accepted dn_wr whose dn_addr differs from the expected offset -> ERROR.
//   Falling dn_download in HEADER -> ERROR (truncated header).
//   Falling dn_download in PAYLOAD -> DRAIN.
//   DRAIN: when the FIFO is empty, pulse load_done, busy=0, go to IDLE.
//    A zero-length payload completes the same way.
//   ERROR: load_err=1 and further bytes are discarded.
//    Entries already queued in the FIFO are still written.
//    On falling dn_download, go to IDLE once the FIFO is empty; busy=0 at that point.
//    load_done is not pulsed.
//  dn_wait = FIFO full OR (state==DRAIN) OR (state==ERROR with FIFO not empty).
//   A rising dn_download while not in IDLE is held off by dn_wait and is accepted on
//   return to IDLE.
//   A dn_wr that arrives while the FIFO is full is a protocol error -> ERROR; the byte is dropped.
//  Handshake: mem_req = FIFO not empty; mem_addr/mem_dout = FIFO head.
//   These must not change while mem_req=1 && mem_ack=0.
//   mem_req=1 && mem_ack=1 pops the head in that cycle.
//   A push and a pop in the same cycle leave the FIFO count unchanged.
//   Latency: a byte written into an empty FIFO at cycle N appears on mem_req at N+1.
//  ADDR_W arithmetic is unsigned. Pointers wrap modulo FIFO_DEPTH.
// TESTING
//  1. Valid VZF0 image, type F1, start 0x7AE9, 5 payload bytes, mem_ack always 1:
//     -> writes to 0x7AE9..0x7AED; load_done one pulse; start=7AE9, end=7AEE, type=F1.
//  2. Same image with mem_ack low for 10 cycles: -> dn_wait rises once 4 entries are queued;
//     no byte is lost or reordered; mem_addr/mem_dout are stable while waiting.
//  3. Header byte 0 = 0x00: -> load_err=1, zero mem_req, no load_done;
//     the next valid load clears load_err.
//  4. start_addr 0xFFFE with 4 payload bytes: -> only FFFE and FFFF are written;
//     load_err=1; end_addr=0x0000.
//  5. dn_index=0 (ROM) download of 100 bytes: -> no mem_req, busy stays 0, outputs unchanged.
//  6. reset asserted after 3 payload bytes with mem_ack=0: -> next cycle mem_req=0, busy=0,
//     FIFO empty; a following valid load behaves exactly as in scenario 1.

Source files
------------

// File: rtl/vz_image_loader.sv
// VZ image loader: validates the VZ header arriving on the ioctl download port and
// streams the payload into main RAM through a small req/ack write FIFO.
module vz_image_loader #(
    parameter int          ADDR_W     = 16,
    parameter int          HDR_LEN    = 24,
    parameter logic [7:0]  IDX_VZ     = 8'd1,
    parameter logic [31:0] MAGIC      = 32'h565A4630,
    parameter int          TYPE_OFS   = 21,
    parameter int          START_OFS  = 22,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              dn_download,
    input  logic [7:0]        dn_index,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [7:0]        dn_data,
    output logic              dn_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [7:0]        load_type,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN, S_ERROR} state_t;

    state_t            state_q, state_d;
    logic              dl_prev_q, dl_prev_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] exp_q, exp_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]        type_q, type_d;
    logic [ADDR_W-1:0] start_q, start_d, end_q, end_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [7:0]        fifo_data_q [FIFO_DEPTH];

    logic              wr_ok, dl_rise, dl_fall, fifo_empty, fifo_full, push, pop;
    logic [ADDR_W:0]   tgt;
    logic [7:0]        magic_byte;
    logic [15:0]       start16;

    always_comb begin
        wr_ok      = dn_wr && (dn_index == IDX_VZ);
        dl_prev_d  = dn_download;
        dl_rise    = dn_download && !dl_prev_q;
        dl_fall    = !dn_download && dl_prev_q;
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop        = !fifo_empty && mem_ack;
        // Extra top bit flags a payload byte that would land past the end of RAM.
        tgt        = {1'b0, start_q} + {1'b0, exp_q - ADDR_W'(HDR_LEN)};
        start16    = 16'(start_q);
        case (exp_q[1:0])
            2'd0:    magic_byte = MAGIC[31:24];
            2'd1:    magic_byte = MAGIC[23:16];
            2'd2:    magic_byte = MAGIC[15:8];
            default: magic_byte = MAGIC[7:0];
        endcase

        state_d = state_q;
        pend_d  = pend_q;
        exp_d   = exp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        type_d  = type_q;
        start_d = start_q;
        end_d   = end_q;
        push    = 1'b0;

        // A new download that shows up mid-load is remembered until we are idle again.
        if (!dn_download) pend_d = 1'b0;
        else if (dl_rise && dn_index == IDX_VZ && state_q != S_IDLE) pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (dn_download && dn_index == IDX_VZ && (dl_rise || pend_q)) begin
                    state_d = S_HEADER;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    exp_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            S_HEADER: begin
                if (wr_ok) begin
                    if (dn_addr != exp_q || (exp_q < ADDR_W'(4) && dn_data != magic_byte)) begin
                        state_d = S_ERROR;
                    end else begin
                        exp_d = exp_q + ADDR_W'(1);
                        if (exp_q == ADDR_W'(TYPE_OFS)) type_d = dn_data;
                        if (exp_q == ADDR_W'(START_OFS)) start_d = ADDR_W'({start16[15:8], dn_data});
                        if (exp_q == ADDR_W'(START_OFS + 1)) start_d = ADDR_W'({dn_data, start16[7:0]});
                        if (exp_q == ADDR_W'(HDR_LEN - 1)) begin
                            state_d = S_PAYLOAD;
                            end_d   = start_d;
                        end
                    end
                end
                if (dl_fall) state_d = (state_d == S_PAYLOAD) ? S_DRAIN : S_ERROR;
            end
            S_PAYLOAD: begin
                if (wr_ok) begin
                    if (dn_addr != exp_q || fifo_full || tgt[ADDR_W]) begin
                        state_d = S_ERROR;
                    end else begin
                        push  = 1'b1;
                        exp_d = exp_q + ADDR_W'(1);
                        end_d = end_q + ADDR_W'(1);
                    end
                end
                if (dl_fall && state_d == S_PAYLOAD) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (!dn_download && fifo_empty) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
        if (state_d == S_ERROR) err_d = 1'b1;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            dl_prev_q <= 1'b0;
            pend_q    <= 1'b0;
            exp_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            type_q    <= '0;
            start_q   <= '0;
            end_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            dl_prev_q <= dl_prev_d;
            pend_q    <= pend_d;
            exp_q     <= exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            type_q    <= type_d;
            start_q   <= start_d;
            end_q     <= end_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= tgt[ADDR_W-1:0];
            fifo_data_q[wr_ptr_q] <= dn_data;
        end
    end

    assign dn_wait    = fifo_full || (state_q == S_DRAIN) || (state_q == S_ERROR && !fifo_empty);
    assign mem_req    = !fifo_empty;
    assign mem_addr   = fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
    assign mem_dout   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign busy       = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign load_type  = type_q;
    assign start_addr = start_q;
    assign end_addr   = end_q;
endmodule

// File: tb/tb_vz_image_loader.sv
// Bench for vz_image_loader: directed VZ loads plus randomized loads, RAM writes
// checked against a queue of expected {addr, data} built from the file contents.
module tb_vz_image_loader;
    localparam int         AW  = 16;
    localparam int         HDR = 24;
    localparam logic [7:0] IDX = 8'd1;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          dn_download = 1'b0;
    logic [7:0]    dn_index = 8'd0;
    logic          dn_wr = 1'b0;
    logic [AW-1:0] dn_addr = '0;
    logic [7:0]    dn_data = '0;
    logic          mem_ack = 1'b0;
    logic          dn_wait, mem_req, busy, load_done, load_err;
    logic [AW-1:0] mem_addr, start_addr, end_addr;
    logic [7:0]    mem_dout, load_type;

    int n_tests = 0;
    int n_fail = 0;
    logic [AW+7:0] exp_q[$];
    int req_cnt = 0;
    int done_cnt = 0;
    bit wait_seen = 0;
    bit busy_seen = 0;
    int ack_mode = 0;
    int ack_hold = 0;
    logic [7:0]    m_type = '0;
    logic [AW-1:0] m_start = '0;
    logic [AW-1:0] m_end = '0;
    logic          m_err = 1'b0;
    bit            prev_hold = 0;
    logic [AW+7:0] prev_word = '0;

    vz_image_loader dut (
        .clk_sys(clk_sys), .reset(reset), .dn_download(dn_download), .dn_index(dn_index),
        .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data), .dn_wait(dn_wait),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .busy(busy), .load_done(load_done), .load_err(load_err), .load_type(load_type),
        .start_addr(start_addr), .end_addr(end_addr)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // RAM-side monitor: handshake stability and write scoreboard
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_hold = 0;
        end else begin
            if (mem_req) req_cnt++;
            if (load_done) done_cnt++;
            if (dn_wait) wait_seen = 1;
            if (busy) busy_seen = 1;
            if (prev_hold) chk("hold_stable", {7'd0, mem_req, mem_addr, mem_dout}, {7'd0, 1'b1, prev_word});
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL unexpected_write: got %0h:%0h expected no write", mem_addr, mem_dout);
                end else begin
                    chk("write", {8'd0, mem_addr, mem_dout}, {8'd0, exp_q.pop_front()});
                end
            end
            prev_hold = mem_req && !mem_ack;
            prev_word = {mem_addr, mem_dout};
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
        if (ack_hold > 0) begin
            mem_ack = 1'b0;
            ack_hold--;
        end else if (ack_mode == 0) begin
            mem_ack = 1'b1;
        end else begin
            mem_ack = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic gap(input int max_gap);
        repeat ($urandom_range(0, max_gap)) tick();
    endtask

    task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
        int k = 0;
        while (dn_wait === 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) begin
            n_tests++;
            n_fail++;
            $error("FAIL wait_timeout: dn_wait high for %0d cycles, expected release", k);
        end
        dn_wr = 1'b1;
        dn_addr = a;
        dn_data = d;
        tick();
        dn_wr = 1'b0;
    endtask

    task automatic send_header(input logic [AW-1:0] start, input logic [7:0] typ, input bit bad,
                               input int max_gap);
        logic [7:0] b;
        for (int i = 0; i < HDR; i++) begin
            case (i)
                0:       b = bad ? 8'h00 : 8'h56;
                1:       b = 8'h5A;
                2:       b = 8'h46;
                3:       b = 8'h30;
                21:      b = typ;
                22:      b = start[7:0];
                23:      b = start[15:8];
                default: b = 8'($urandom);
            endcase
            gap(max_gap);
            send_byte(AW'(i), b);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_err"}, {31'd0, load_err}, {31'd0, m_err});
        chk({tag, "_type"}, {24'd0, load_type}, {24'd0, m_type});
        chk({tag, "_start"}, {16'd0, start_addr}, {16'd0, m_start});
        chk({tag, "_end"}, {16'd0, end_addr}, {16'd0, m_end});
    endtask

    task automatic run_load(input logic [AW-1:0] start, input logic [7:0] typ, input int n,
                            input bit bad, input int amode, input int hold, input int max_gap);
        logic [7:0] pay[$];
        int written;
        bit err;
        int d0, r0, k;
        ack_mode = amode;
        for (int p = 0; p < n; p++) pay.push_back(8'($urandom));
        // Reference: payload byte p goes to start+p until the top of RAM is passed
        err = bad;
        written = 0;
        if (!bad) begin
            m_type = typ;
            m_start = start;
            for (int p = 0; p < n; p++) begin
                if (int'(start) + p > 65535) begin
                    err = 1;
                    break;
                end
                exp_q.push_back({AW'(int'(start) + p), pay[p]});
                written++;
            end
            m_end = AW'(int'(start) + written);
        end
        m_err = err;
        d0 = done_cnt;
        r0 = req_cnt;
        wait_seen = 0;

        dn_index = IDX;
        dn_download = 1'b1;
        tick();
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_err_clr", {31'd0, load_err}, 32'd0);
        send_header(start, typ, bad, max_gap);
        ack_hold = hold;
        for (int p = 0; p < n; p++) begin
            gap(max_gap);
            send_byte(AW'(HDR + p), pay[p]);
            if (p == 0 && amode == 0 && hold == 0 && !bad) begin
                chk("latency_req", {31'd0, mem_req}, 32'd1);
                chk("latency_word", {8'd0, mem_addr, mem_dout}, {8'd0, start, pay[0]});
            end
        end
        dn_download = 1'b0;
        tick();
        k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) begin
            n_tests++;
            n_fail++;
            $error("FAIL end_timeout: busy=%0b queued=%0d, expected idle and drained", busy, exp_q.size());
        end
        tick();
        tick();
        check_outputs("load");
        chk("done_pulses", done_cnt - d0, err ? 32'd0 : 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_req", {31'd0, mem_req}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
        if (bad) chk("bad_no_req", req_cnt - r0, 32'd0);
        if (hold >= 8 && n >= 5) chk("wait_seen", {31'd0, wait_seen}, 32'd1);
    endtask

    task automatic rom_download(input int n);
        int r0;
        ack_mode = 0;
        r0 = req_cnt;
        busy_seen = 0;
        dn_index = 8'd0;
        dn_download = 1'b1;
        tick();
        for (int i = 0; i < n; i++) send_byte(AW'(i), 8'($urandom));
        dn_download = 1'b0;
        tick();
        tick();
        chk("rom_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("rom_no_req", req_cnt - r0, 32'd0);
        check_outputs("rom");
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wait", {31'd0, dn_wait}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_word", {8'd0, mem_addr, mem_dout}, 32'd0);
        check_outputs("rst");
        reset = 1'b0;
        tick();

        run_load(16'h7AE9, 8'hF1, 5, 0, 0, 0, 0);
        run_load(16'h7AE9, 8'hF1, 5, 0, 0, 10, 0);
        run_load(16'h1234, 8'hF0, 3, 1, 0, 0, 0);
        run_load(16'h4000, 8'hF0, 2, 0, 0, 0, 1);
        run_load(16'hFFFE, 8'hF1, 4, 0, 0, 0, 0);
        chk("ovf_end", {16'd0, end_addr}, 32'd0);
        rom_download(100);

        // Reset in the middle of a payload with RAM stalled
        ack_mode = 0;
        ack_hold = 60;
        dn_index = IDX;
        dn_download = 1'b1;
        tick();
        send_header(16'h5000, 8'hF0, 0, 0);
        for (int p = 0; p < 3; p++) send_byte(AW'(HDR + p), 8'($urandom));
        chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        dn_download = 1'b0;
        tick();
        exp_q.delete();
        m_type = '0;
        m_start = '0;
        m_end = '0;
        m_err = 1'b0;
        chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_wait", {31'd0, dn_wait}, 32'd0);
        check_outputs("mid_rst");
        reset = 1'b0;
        ack_hold = 0;
        tick();
        run_load(16'h7AE9, 8'hF1, 5, 0, 0, 0, 0);

        for (int it = 0; it < 10; it++) begin
            logic [AW-1:0] st;
            st = ($urandom_range(0, 2) == 0) ? (16'hFFF8 + AW'($urandom_range(0, 7))) : AW'($urandom);
            run_load(st, 8'hF0 + 8'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                     $urandom_range(0, 5) == 0, int'($urandom_range(0, 1)), 0, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
